// File: rtl/grid_vga_renderer.sv
// VGA front-end for the 8x8 game board: 640x480@60 timing, cell memory address walk,
// and a two-stage pixel pipeline with grid lines and mouse-cell highlight.
module grid_vga_renderer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned BOARD_X0 = 128,
  parameter int unsigned BOARD_Y0 = 48,
  parameter int unsigned CELL     = 48
) (
  input  logic       clk_25M_in,
  input  logic       reset,
  input  logic [3:0] status_pointed_cell,
  input  logic [2:0] mouse_cell_x,
  input  logic [2:0] mouse_cell_y,
  output logic [2:0] pointer_cell_x,
  output logic [2:0] pointer_cell_y,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned CW      = $clog2(CELL);
  localparam int unsigned SPAN    = 8 * CELL;

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [CW-1:0] cell_px, cell_py;
  logic [2:0]    cell_x, cell_y;
  logic          line_end, bx_cur, bx_nxt, by_cur, by_nxt;

  // Next counter values and board-window membership of current and next position
  always_comb begin
    line_end = (h_cnt == HW'(H_TOTAL - 1));
    h_nxt    = line_end ? '0 : h_cnt + HW'(1);
    v_nxt    = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
    bx_cur   = (h_cnt >= HW'(BOARD_X0)) && (h_cnt < HW'(BOARD_X0 + SPAN));
    bx_nxt   = (h_nxt >= HW'(BOARD_X0)) && (h_nxt < HW'(BOARD_X0 + SPAN));
    by_cur   = (v_cnt >= VW'(BOARD_Y0)) && (v_cnt < VW'(BOARD_Y0 + SPAN));
    by_nxt   = (v_nxt >= VW'(BOARD_Y0)) && (v_nxt < VW'(BOARD_Y0 + SPAN));
  end

  // Stage 0: raster and cell-geometry counters; cell counters rest at 0 off-board
  always_ff @(posedge clk_25M_in) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      cell_px <= '0;
      cell_x  <= '0;
      cell_py <= '0;
      cell_y  <= '0;
    end else begin
      h_cnt <= h_nxt;
      if (bx_cur && bx_nxt) begin
        if (cell_px == CW'(CELL - 1)) begin
          cell_px <= '0;
          cell_x  <= cell_x + 3'd1;
        end else begin
          cell_px <= cell_px + CW'(1);
        end
      end else begin
        cell_px <= '0;
        cell_x  <= '0;
      end
      if (line_end) begin
        v_cnt <= v_nxt;
        if (by_cur && by_nxt) begin
          if (cell_py == CW'(CELL - 1)) begin
            cell_py <= '0;
            cell_y  <= cell_y + 3'd1;
          end else begin
            cell_py <= cell_py + CW'(1);
          end
        end else begin
          cell_py <= '0;
          cell_y  <= '0;
        end
      end
    end
  end

  assign pointer_cell_x = cell_x;
  assign pointer_cell_y = cell_y;

  logic hsync_raw, vsync_raw, blank0, board0, grid0, cursor0, first0;
  logic edge_px, edge_py;

  // Stage-0 per-pixel flags
  always_comb begin
    hsync_raw = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vsync_raw = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    blank0    = (h_cnt >= HW'(H_ACTIVE)) || (v_cnt >= VW'(V_ACTIVE));
    board0    = bx_cur && by_cur;
    grid0     = (cell_px == '0) || (cell_py == '0) ||
                (h_cnt == HW'(BOARD_X0 + SPAN - 1)) || (v_cnt == VW'(BOARD_Y0 + SPAN - 1));
    edge_px   = (cell_px < CW'(2)) || (cell_px >= CW'(CELL - 2));
    edge_py   = (cell_py < CW'(2)) || (cell_py >= CW'(CELL - 2));
    cursor0   = (cell_x == mouse_cell_x) && (cell_y == mouse_cell_y) && (edge_px || edge_py);
    first0    = (h_cnt == '0) && (v_cnt == '0);
  end

  logic s1_hsync, s1_vsync, s1_blank, s1_board, s1_grid, s1_cursor, s1_first;

  // Stage 1: flags wait alongside the memory's registered read
  always_ff @(posedge clk_25M_in) begin
    if (reset) begin
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_blank  <= 1'b0;
      s1_board  <= 1'b0;
      s1_grid   <= 1'b0;
      s1_cursor <= 1'b0;
      s1_first  <= 1'b0;
    end else begin
      s1_hsync  <= hsync_raw;
      s1_vsync  <= vsync_raw;
      s1_blank  <= blank0;
      s1_board  <= board0;
      s1_grid   <= grid0;
      s1_cursor <= cursor0;
      s1_first  <= first0;
    end
  end

  logic [11:0] pix;

  // Pixel colour by priority: blank/off-board, cursor, grid, cell fill
  always_comb begin
    pix = 12'h000;
    if (!s1_blank && s1_board) begin
      if (s1_cursor) begin
        pix = 12'hFF0;
      end else if (s1_grid) begin
        pix = 12'hFFF;
      end else begin
        case (status_pointed_cell)
          4'd0:    pix = 12'h222;
          4'd1:    pix = 12'hF00;
          4'd2:    pix = 12'h00F;
          4'd3:    pix = 12'h0F0;
          default: pix = {status_pointed_cell, status_pointed_cell, status_pointed_cell};
        endcase
      end
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk_25M_in) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= s1_hsync;
      vsync       <= s1_vsync;
      vga_r       <= pix[11:8];
      vga_g       <= pix[7:4];
      vga_b       <= pix[3:0];
      frame_start <= s1_first;
    end
  end

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Bench for grid_vga_renderer: full-size instance for line timing and pixels, a shrunken
// instance for frame timing, cursor and mid-frame reset. Pixels checked via scoreboard.
module tb_grid_vga_renderer;

  logic       clk;
  logic       reset, reset_s;
  logic [3:0] stat_m, stat_s;
  logic [2:0] mouse_mx, mouse_my, mouse_sx, mouse_sy;
  logic [2:0] ptr_mx, ptr_my, ptr_sx, ptr_sy;
  logic       hs_m, vs_m, fs_m, hs_s, vs_s, fs_s;
  logic [3:0] r_m, g_m, b_m, r_s, g_s, b_s;

  logic [3:0] mem_m [64];
  logic [3:0] mem_s [64];

  int n_tests = 0;
  int n_fail  = 0;
  int t_m = 0;
  int t_s = 0;

  localparam int RST_T = 2 * 17600 + 52 * 200 + 44;

  typedef struct {
    string       tag;
    int          due;
    logic [11:0] exp;
  } sb_e;

  sb_e q_m[$];
  sb_e q_s[$];

  int tm_h [10] = '{130, 128, 200, 100, 175, 176, 511, 600, 700, 300};
  int tm_v [10] = '{50,  50,  50,  50,  50,  49,  50,  50,  50,  47};
  int ts_h [18] = '{18, 27, 35, 60, 44, 44, 40, 41, 46, 47, 44, 44, 44, 44, 44, 42, 48, 170};
  int ts_v [18] = '{10, 10, 10, 30, 71, 72, 50, 50, 50, 50, 48, 49, 54, 55, 52, 51, 50, 10};
  int pm_h [10] = '{100, 127, 128, 175, 176, 223, 464, 511, 512, 700};
  int ps_v [8]  = '{7, 8, 23, 24, 31, 32, 71, 72};

  int hs_fall [2] = '{-1, -1};
  int vs_fall [2] = '{-1, -1};
  int fs_t    [2] = '{-1, -1};
  int hs_rise = -1;
  int vs_rise = -1;
  int n_hsf = 0, n_vsf = 0, n_fs = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  grid_vga_renderer u_main (
    .clk_25M_in(clk), .reset(reset), .status_pointed_cell(stat_m),
    .mouse_cell_x(mouse_mx), .mouse_cell_y(mouse_my),
    .pointer_cell_x(ptr_mx), .pointer_cell_y(ptr_my),
    .hsync(hs_m), .vsync(vs_m), .vga_r(r_m), .vga_g(g_m), .vga_b(b_m),
    .frame_start(fs_m)
  );

  grid_vga_renderer #(
    .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(16),
    .V_ACTIVE(80), .V_FP(3), .V_SYNC(2), .V_BP(3),
    .BOARD_X0(16), .BOARD_Y0(8), .CELL(8)
  ) u_small (
    .clk_25M_in(clk), .reset(reset_s), .status_pointed_cell(stat_s),
    .mouse_cell_x(mouse_sx), .mouse_cell_y(mouse_sy),
    .pointer_cell_x(ptr_sx), .pointer_cell_y(ptr_sy),
    .hsync(hs_s), .vsync(vs_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .frame_start(fs_s)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Cell memories with one-cycle registered read; bench cycle counters since release
  always @(posedge clk) begin
    stat_m <= mem_m[{ptr_my, ptr_mx}];
    stat_s <= mem_s[{ptr_sy, ptr_sx}];
    t_m    <= reset ? 0 : t_m + 1;
    t_s    <= reset_s ? 0 : t_s + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_ptr(input int p, input int base, input int c);
    return (p >= base && p < base + 8 * c) ? (p - base) / c : 0;
  endfunction

  // Reference pixel colour from absolute coordinates (sel 0 = full-size, 1 = small)
  function automatic logic [11:0] exp_rgb(input int sel, input int h, input int v);
    int ha, va, x0, y0, c, mx, my, px, py, cx, cy;
    logic [3:0] st;
    if (sel == 0) begin
      ha = 640; va = 480; x0 = 128; y0 = 48; c = 48; mx = 7; my = 7;
    end else begin
      ha = 160; va = 80; x0 = 16; y0 = 8; c = 8; mx = 3; my = 5;
    end
    if (h >= ha || v >= va) return 12'h000;
    if (h < x0 || h >= x0 + 8 * c || v < y0 || v >= y0 + 8 * c) return 12'h000;
    px = (h - x0) % c; cx = (h - x0) / c;
    py = (v - y0) % c; cy = (v - y0) / c;
    if (cx == mx && cy == my && (px < 2 || px >= c - 2 || py < 2 || py >= c - 2)) return 12'hFF0;
    if (px == 0 || py == 0 || h == x0 + 8 * c - 1 || v == y0 + 8 * c - 1) return 12'hFFF;
    st = (sel == 0) ? mem_m[cy * 8 + cx] : mem_s[cy * 8 + cx];
    case (st)
      4'd0:    return 12'h222;
      4'd1:    return 12'hF00;
      4'd2:    return 12'h00F;
      4'd3:    return 12'h0F0;
      default: return {st, st, st};
    endcase
  endfunction

  // Per-cycle work: push expected pixels at stage 0, pop and compare two cycles later
  task automatic monitor();
    int  h, v;
    sb_e e;
    if (reset) q_m.delete();
    else begin
      h = t_m % 800;
      v = (t_m / 800) % 525;
      for (int i = 0; i < 10; i++)
        if (h == tm_h[i] && v == tm_v[i]) begin
          e.tag = $sformatf("pix_m(%0d,%0d)", h, v);
          e.due = t_m + 2;
          e.exp = exp_rgb(0, h, v);
          q_m.push_back(e);
        end
      while (q_m.size() > 0 && q_m[0].due <= t_m) begin
        e = q_m.pop_front();
        check(e.tag, 32'({r_m, g_m, b_m}), 32'(e.exp));
      end
      if (v == 50)
        for (int i = 0; i < 10; i++)
          if (h == pm_h[i]) check($sformatf("ptr_x_m h=%0d", h), 32'(ptr_mx), 32'(exp_ptr(h, 128, 48)));
      if (t_m >= 1 && t_m <= 3) check($sformatf("fs_m t=%0d", t_m), 32'(fs_m), 32'(t_m == 2));
      if (prev_hs && !hs_m && n_hsf < 2) begin hs_fall[n_hsf] = t_m; n_hsf++; end
      if (!prev_hs && hs_m && hs_rise < 0) hs_rise = t_m;
    end
    prev_hs = hs_m;

    if (reset_s) q_s.delete();
    else begin
      h = t_s % 200;
      v = (t_s / 200) % 88;
      for (int i = 0; i < 18; i++)
        if (h == ts_h[i] && v == ts_v[i]) begin
          e.tag = $sformatf("pix_s(%0d,%0d)", h, v);
          e.due = t_s + 2;
          e.exp = exp_rgb(1, h, v);
          q_s.push_back(e);
        end
      while (q_s.size() > 0 && q_s[0].due <= t_s) begin
        e = q_s.pop_front();
        check(e.tag, 32'({r_s, g_s, b_s}), 32'(e.exp));
      end
      if (h == 5)
        for (int i = 0; i < 8; i++)
          if (v == ps_v[i]) check($sformatf("ptr_y_s v=%0d", v), 32'(ptr_sy), 32'(exp_ptr(v, 8, 8)));
      if (prev_vs && !vs_s && n_vsf < 2) begin vs_fall[n_vsf] = t_s; n_vsf++; end
      if (!prev_vs && vs_s && vs_rise < 0) vs_rise = t_s;
      if (fs_s && n_fs < 2) begin fs_t[n_fs] = t_s; n_fs++; end
    end
    prev_vs = vs_s;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem_m[i] = 4'd0; mem_s[i] = 4'd0; end
    mem_m[0]  = 4'd1;
    mem_s[0]  = 4'd2;
    mem_s[1]  = 4'd3;
    mem_s[2]  = 4'd12;
    mem_s[43] = 4'd9;
    mouse_mx = 3'd7; mouse_my = 3'd7;
    mouse_sx = 3'd3; mouse_sy = 3'd5;
    reset = 1'b1; reset_s = 1'b1;

    repeat (3) begin
      tick();
      check("rst_sync_m", 32'({hs_m, vs_m}), 32'(2'b11));
      check("rst_rgb_m", 32'({r_m, g_m, b_m, fs_m}), 32'(0));
      check("rst_ptr_s", 32'({ptr_sx, ptr_sy}), 32'(0));
    end
    reset = 1'b0; reset_s = 1'b0;

    for (int i = 0; i < 60000 && t_s != RST_T; i++) tick();
    check("reach_rst_point", 32'(t_s), 32'(RST_T));
    check("rgb_s_pre_rst", 32'({r_s, g_s, b_s}), 32'(12'h999));
    check("ptr_s_pre_rst", 32'({ptr_sx, ptr_sy}), 32'({3'd3, 3'd5}));

    reset_s = 1'b1;
    tick();
    check("midrst_sync_s", 32'({hs_s, vs_s}), 32'(2'b11));
    check("midrst_rgb_s", 32'({r_s, g_s, b_s, fs_s}), 32'(0));
    check("midrst_ptr_s", 32'({ptr_sx, ptr_sy}), 32'(0));
    reset_s = 1'b0;
    tick();
    check("midrst_fs_t1", 32'(fs_s), 32'(0));
    tick();
    check("midrst_fs_t2", 32'(fs_s), 32'(1));

    for (int i = 0; i < 20000 && t_s < 11000; i++) tick();

    check("hs_first_fall", 32'(hs_fall[0]), 32'(658));
    check("hs_period", 32'(hs_fall[1] - hs_fall[0]), 32'(800));
    check("hs_low_width", 32'(hs_rise - hs_fall[0]), 32'(96));
    check("vs_first_fall", 32'(vs_fall[0]), 32'(16602));
    check("vs_period", 32'(vs_fall[1] - vs_fall[0]), 32'(17600));
    check("vs_low_width", 32'(vs_rise - vs_fall[0]), 32'(400));
    check("fs_s_first", 32'(fs_t[0]), 32'(2));
    check("fs_s_period", 32'(fs_t[1] - fs_t[0]), 32'(17600));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
